// File: rtl/instr_register_mc.sv
// Instruction register file: single-cycle ALU ops commit on accept, nonzero-divisor
// DIV/MOD run a bit-serial restoring divider first. Registered read-before-write port.
module instr_register_mc #(
   parameter int DEPTH  = 32,
   parameter int OP_W   = 32,
   parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   parameter int RES_W  = 2 * OP_W
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    load_en,
   output logic                    load_ready,
   input  logic [2:0]              opcode,
   input  logic signed [OP_W-1:0]  operand_a,
   input  logic signed [OP_W-1:0]  operand_b,
   input  logic [ADDR_W-1:0]       write_pointer,
   input  logic [ADDR_W-1:0]       read_pointer,
   output logic [2:0]              rd_opc,
   output logic signed [OP_W-1:0]  rd_op_a,
   output logic signed [OP_W-1:0]  rd_op_b,
   output logic signed [RES_W-1:0] rd_result,
   output logic                    rd_valid,
   output logic                    wr_done
);

   localparam int CNT_W = $clog2(OP_W) + 1;
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   localparam logic [2:0] OP_ZERO  = 3'd0;
   localparam logic [2:0] OP_PASSA = 3'd1;
   localparam logic [2:0] OP_PASSB = 3'd2;
   localparam logic [2:0] OP_ADD   = 3'd3;
   localparam logic [2:0] OP_SUB   = 3'd4;
   localparam logic [2:0] OP_MULT  = 3'd5;
   localparam logic [2:0] OP_DIV   = 3'd6;
   localparam logic [2:0] OP_MOD   = 3'd7;

   typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_WRITE} state_e;

   function automatic logic [OP_W-1:0] magnitude(input logic signed [OP_W-1:0] v);
      return v[OP_W-1] ? OP_W'(-v) : OP_W'(v);
   endfunction

   function automatic logic signed [RES_W-1:0] apply_sign(input logic [OP_W-1:0] mag,
                                                          input logic neg);
      logic signed [RES_W-1:0] ext;
      ext = $signed({{(RES_W-OP_W){1'b0}}, mag});
      return neg ? -ext : ext;
   endfunction

   state_e                  state_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [OP_W-1:0]         dvd_q, dvs_q, rem_q;
   logic                    neg_a_q, neg_q_q;
   logic [2:0]              pend_opc_q;
   logic signed [OP_W-1:0]  pend_a_q, pend_b_q;
   logic [ADDR_W-1:0]       pend_addr_q;
   logic                    load_ready_q, wr_done_q;

   logic [2:0]              mem_opc_q [DEPTH];
   logic [2:0]              mem_opc_d [DEPTH];
   logic signed [OP_W-1:0]  mem_a_q   [DEPTH];
   logic signed [OP_W-1:0]  mem_a_d   [DEPTH];
   logic signed [OP_W-1:0]  mem_b_q   [DEPTH];
   logic signed [OP_W-1:0]  mem_b_d   [DEPTH];
   logic signed [RES_W-1:0] mem_res_q [DEPTH];
   logic signed [RES_W-1:0] mem_res_d [DEPTH];
   logic                    mem_vld_q [DEPTH];
   logic                    mem_vld_d [DEPTH];

   logic [2:0]              rd_opc_q, rd_opc_d;
   logic signed [OP_W-1:0]  rd_op_a_q, rd_op_a_d, rd_op_b_q, rd_op_b_d;
   logic signed [RES_W-1:0] rd_result_q, rd_result_d;
   logic                    rd_valid_q, rd_valid_d;

   logic                    accept, start_div, in_write, commit, commit_hit;
   logic signed [RES_W-1:0] a_ext, b_ext, fast_res, div_res, commit_res;
   logic [2:0]              commit_opc;
   logic signed [OP_W-1:0]  commit_a, commit_b;
   logic [ADDR_W-1:0]       commit_addr;
   logic [OP_W:0]           rem_shift, rem_diff;
   logic                    rem_ge;
   logic [OP_W-1:0]         rem_next;

   always_comb begin
      accept    = load_en & load_ready_q;
      start_div = accept & ((opcode == OP_DIV) | (opcode == OP_MOD)) & (operand_b != '0);
      in_write  = (state_q == S_WRITE);
      commit    = in_write | (accept & ~start_div);

      a_ext = RES_W'(operand_a);
      b_ext = RES_W'(operand_b);
      case (opcode)
         OP_ZERO:  fast_res = '0;
         OP_PASSA: fast_res = a_ext;
         OP_PASSB: fast_res = b_ext;
         OP_ADD:   fast_res = a_ext + b_ext;
         OP_SUB:   fast_res = a_ext - b_ext;
         OP_MULT:  fast_res = a_ext * b_ext;
         default:  fast_res = '0;
      endcase

      // Restoring step: borrow out of the trial subtraction means the bit is 0.
      rem_shift = {rem_q, dvd_q[OP_W-1]};
      rem_diff  = rem_shift - {1'b0, dvs_q};
      rem_ge    = ~rem_diff[OP_W];
      rem_next  = rem_ge ? rem_diff[OP_W-1:0] : rem_shift[OP_W-1:0];

      div_res = (pend_opc_q == OP_DIV) ? apply_sign(dvd_q, neg_q_q)
                                       : apply_sign(rem_q, neg_a_q);

      commit_opc  = in_write ? pend_opc_q  : opcode;
      commit_a    = in_write ? pend_a_q    : operand_a;
      commit_b    = in_write ? pend_b_q    : operand_b;
      commit_addr = in_write ? pend_addr_q : write_pointer;
      commit_res  = in_write ? div_res     : fast_res;
      commit_hit  = commit & ({1'b0, commit_addr} < DEPTH_C);
   end

   always_comb begin
      mem_opc_d = mem_opc_q;
      mem_a_d   = mem_a_q;
      mem_b_d   = mem_b_q;
      mem_res_d = mem_res_q;
      mem_vld_d = mem_vld_q;
      if (commit_hit) begin
         mem_opc_d[commit_addr] = commit_opc;
         mem_a_d[commit_addr]   = commit_a;
         mem_b_d[commit_addr]   = commit_b;
         mem_res_d[commit_addr] = commit_res;
         mem_vld_d[commit_addr] = 1'b1;
      end
   end

   always_comb begin
      rd_opc_d    = '0;
      rd_op_a_d   = '0;
      rd_op_b_d   = '0;
      rd_result_d = '0;
      rd_valid_d  = 1'b0;
      if ({1'b0, read_pointer} < DEPTH_C) begin
         rd_opc_d    = mem_opc_q[read_pointer];
         rd_op_a_d   = mem_a_q[read_pointer];
         rd_op_b_d   = mem_b_q[read_pointer];
         rd_result_d = mem_res_q[read_pointer];
         rd_valid_d  = mem_vld_q[read_pointer];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_opc_q   <= '{default: '0};
         mem_a_q     <= '{default: '0};
         mem_b_q     <= '{default: '0};
         mem_res_q   <= '{default: '0};
         mem_vld_q   <= '{default: 1'b0};
         rd_opc_q    <= '0;
         rd_op_a_q   <= '0;
         rd_op_b_q   <= '0;
         rd_result_q <= '0;
         rd_valid_q  <= 1'b0;
      end else begin
         mem_opc_q   <= mem_opc_d;
         mem_a_q     <= mem_a_d;
         mem_b_q     <= mem_b_d;
         mem_res_q   <= mem_res_d;
         mem_vld_q   <= mem_vld_d;
         rd_opc_q    <= rd_opc_d;
         rd_op_a_q   <= rd_op_a_d;
         rd_op_b_q   <= rd_op_b_d;
         rd_result_q <= rd_result_d;
         rd_valid_q  <= rd_valid_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         dvd_q        <= '0;
         dvs_q        <= '0;
         rem_q        <= '0;
         neg_a_q      <= 1'b0;
         neg_q_q      <= 1'b0;
         pend_opc_q   <= '0;
         pend_a_q     <= '0;
         pend_b_q     <= '0;
         pend_addr_q  <= '0;
         load_ready_q <= 1'b1;
         wr_done_q    <= 1'b0;
      end else begin
         wr_done_q <= commit;
         case (state_q)
            S_IDLE: begin
               if (start_div) begin
                  state_q      <= S_DIVIDE;
                  load_ready_q <= 1'b0;
                  cnt_q        <= '0;
                  dvd_q        <= magnitude(operand_a);
                  dvs_q        <= magnitude(operand_b);
                  rem_q        <= '0;
                  neg_a_q      <= operand_a[OP_W-1];
                  neg_q_q      <= operand_a[OP_W-1] ^ operand_b[OP_W-1];
                  pend_opc_q   <= opcode;
                  pend_a_q     <= operand_a;
                  pend_b_q     <= operand_b;
                  pend_addr_q  <= write_pointer;
               end
            end
            S_DIVIDE: begin
               dvd_q <= {dvd_q[OP_W-2:0], rem_ge};
               rem_q <= rem_next;
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(OP_W-1)) state_q <= S_WRITE;
            end
            S_WRITE: begin
               state_q      <= S_IDLE;
               load_ready_q <= 1'b1;
            end
            default: begin
               state_q      <= S_IDLE;
               load_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign load_ready = load_ready_q;
   assign wr_done    = wr_done_q;
   assign rd_opc     = rd_opc_q;
   assign rd_op_a    = rd_op_a_q;
   assign rd_op_b    = rd_op_b_q;
   assign rd_result  = rd_result_q;
   assign rd_valid   = rd_valid_q;

endmodule

// File: tb/tb_instr_register_mc.sv
// Bench for instr_register_mc: directed vector table, read-before-write and reset-abort
// sequences, randomized traffic against an arithmetic reference model, DEPTH=24 bounds.
module tb_instr_register_mc;

   localparam int OP_W = 32;
   typedef logic signed [63:0] s64;

   typedef struct {
      logic [2:0]         opc;
      logic signed [31:0] a;
      logic signed [31:0] b;
      logic [4:0]         p;
      s64                 res;
      int                 lat;
   } vec_t;

   logic clk = 1'b0;
   logic reset_n = 1'b1;
   logic load_en = 1'b0;
   logic [2:0] opcode = '0;
   logic signed [31:0] operand_a = '0, operand_b = '0;
   logic [4:0] write_pointer = '0, read_pointer = '0;
   logic load_ready, rd_valid, wr_done;
   logic [2:0] rd_opc;
   logic signed [31:0] rd_op_a, rd_op_b;
   s64 rd_result;

   logic d2_load_en = 1'b0;
   logic [2:0] d2_opcode = '0;
   logic signed [31:0] d2_a = '0, d2_b = '0;
   logic [4:0] d2_wp = '0, d2_rp = '0;
   logic d2_load_ready, d2_rd_valid, d2_wr_done;
   logic [2:0] d2_rd_opc;
   logic signed [31:0] d2_rd_op_a, d2_rd_op_b;
   s64 d2_rd_result;

   int checks = 0;
   int failures = 0;

   logic [2:0]         m_opc [32];
   logic signed [31:0] m_a   [32];
   logic signed [31:0] m_b   [32];
   s64                 m_res [32];
   bit                 m_vld [32];
   int                 busy = 0;
   logic [2:0]         p_opc;
   logic signed [31:0] p_a, p_b;
   logic [4:0]         p_p;

   vec_t tbl [16];

   instr_register_mc #(.DEPTH(32), .OP_W(OP_W)) dut (
      .clk(clk), .reset_n(reset_n), .load_en(load_en), .load_ready(load_ready),
      .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
      .write_pointer(write_pointer), .read_pointer(read_pointer),
      .rd_opc(rd_opc), .rd_op_a(rd_op_a), .rd_op_b(rd_op_b), .rd_result(rd_result),
      .rd_valid(rd_valid), .wr_done(wr_done));

   instr_register_mc #(.DEPTH(24), .OP_W(OP_W)) dut24 (
      .clk(clk), .reset_n(reset_n), .load_en(d2_load_en), .load_ready(d2_load_ready),
      .opcode(d2_opcode), .operand_a(d2_a), .operand_b(d2_b),
      .write_pointer(d2_wp), .read_pointer(d2_rp),
      .rd_opc(d2_rd_opc), .rd_op_a(d2_rd_op_a), .rd_op_b(d2_rd_op_b),
      .rd_result(d2_rd_result), .rd_valid(d2_rd_valid), .wr_done(d2_wr_done));

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   function automatic s64 ref_result(input logic [2:0] op, input logic signed [31:0] a,
                                     input logic signed [31:0] b);
      s64 x, y;
      x = 64'(a);
      y = 64'(b);
      case (op)
         3'd0: return 0;
         3'd1: return x;
         3'd2: return y;
         3'd3: return x + y;
         3'd4: return x - y;
         3'd5: return x * y;
         3'd6: return (y == 0) ? 0 : x / y;
         default: return (y == 0) ? 0 : x % y;
      endcase
   endfunction

   function automatic logic signed [31:0] rand_val();
      case ($urandom_range(0, 6))
         0: return 32'sh80000000;
         1: return 32'sh7fffffff;
         2: return -32'sd1;
         3: return 32'sd0;
         4: return 32'(int'($urandom_range(0, 40)) - 20);
         default: return 32'($urandom());
      endcase
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 32; i++) begin
         m_opc[i] = '0; m_a[i] = '0; m_b[i] = '0; m_res[i] = '0; m_vld[i] = 1'b0;
      end
      busy = 0;
   endtask

   task automatic pulse_reset();
      reset_n = 1'b0;
      #1;
      repeat (2) tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic do_write(input logic [2:0] op, input logic signed [31:0] a,
                           input logic signed [31:0] b, input logic [4:0] p,
                           output int lat, output int low);
      int guard;
      guard = 0;
      while (!load_ready && guard < 100) begin
         tick();
         guard++;
      end
      load_en = 1'b1; opcode = op; operand_a = a; operand_b = b; write_pointer = p;
      tick();
      load_en = 1'b0;
      lat = 0;
      low = 0;
      while (lat < 100) begin
         if (!load_ready) low++;
         if (wr_done) break;
         tick();
         lat++;
      end
   endtask

   task automatic rand_cycle(input bit allow);
      logic [2:0] e_opc, c_opc;
      logic signed [31:0] e_a, e_b, c_a, c_b;
      logic [4:0] c_p;
      s64 e_res;
      bit e_vld, commit;
      load_en = allow && ($urandom_range(0, 2) != 0);
      opcode = 3'($urandom_range(0, 7));
      operand_a = rand_val();
      operand_b = rand_val();
      write_pointer = 5'($urandom_range(0, 31));
      read_pointer = 5'($urandom_range(0, 31));
      chk("rnd_load_ready", 64'(load_ready), 64'(busy == 0));
      commit = 1'b0;
      c_opc = '0; c_a = '0; c_b = '0; c_p = '0;
      if (busy != 0) begin
         busy--;
         if (busy == 0) begin
            commit = 1'b1; c_opc = p_opc; c_a = p_a; c_b = p_b; c_p = p_p;
         end
      end else if (load_en) begin
         if ((opcode == 3'd6 || opcode == 3'd7) && operand_b != 0) begin
            busy = OP_W + 1;
            p_opc = opcode; p_a = operand_a; p_b = operand_b; p_p = write_pointer;
         end else begin
            commit = 1'b1; c_opc = opcode; c_a = operand_a; c_b = operand_b; c_p = write_pointer;
         end
      end
      e_opc = m_opc[read_pointer]; e_a = m_a[read_pointer]; e_b = m_b[read_pointer];
      e_res = m_res[read_pointer]; e_vld = m_vld[read_pointer];
      tick();
      chk("rnd_rd_opc", 64'(rd_opc), 64'(e_opc));
      chk("rnd_rd_op_a", 64'(rd_op_a), 64'(e_a));
      chk("rnd_rd_op_b", 64'(rd_op_b), 64'(e_b));
      chk("rnd_rd_result", rd_result, e_res);
      chk("rnd_rd_valid", 64'(rd_valid), 64'(e_vld));
      chk("rnd_wr_done", 64'(wr_done), 64'(commit));
      if (commit) begin
         m_opc[c_p] = c_opc; m_a[c_p] = c_a; m_b[c_p] = c_b;
         m_res[c_p] = ref_result(c_opc, c_a, c_b); m_vld[c_p] = 1'b1;
      end
   endtask

   initial begin
      int lat, low, n_done;

      tbl[0]  = '{3'd3, 32'sd5, -32'sd3, 5'd0, 64'sd2, 0};
      tbl[1]  = '{3'd6, -32'sd17, 32'sd5, 5'd3, -64'sd3, 33};
      tbl[2]  = '{3'd7, -32'sd17, 32'sd5, 5'd4, -64'sd2, 33};
      tbl[3]  = '{3'd6, 32'sd9, 32'sd0, 5'd7, 64'sd0, 0};
      tbl[4]  = '{3'd5, 32'sh80000000, 32'sh80000000, 5'd1, 64'sh4000000000000000, 0};
      tbl[5]  = '{3'd2, 32'sd123, 32'sd6, 5'd2, 64'sd6, 0};
      tbl[6]  = '{3'd4, 32'sh80000000, 32'sd1, 5'd8, 64'shFFFFFFFF7FFFFFFF, 0};
      tbl[7]  = '{3'd3, 32'sh7fffffff, 32'sh7fffffff, 5'd9, 64'sh00000000FFFFFFFE, 0};
      tbl[8]  = '{3'd6, 32'sh80000000, -32'sd1, 5'd10, 64'sh0000000080000000, 33};
      tbl[9]  = '{3'd7, 32'sd17, -32'sd5, 5'd11, 64'sd2, 33};
      tbl[10] = '{3'd7, 32'sd9, 32'sd0, 5'd12, 64'sd0, 0};
      tbl[11] = '{3'd0, 32'sd7, 32'sd8, 5'd13, 64'sd0, 0};
      tbl[12] = '{3'd1, -32'sd9, 32'sd4, 5'd31, -64'sd9, 0};
      tbl[13] = '{3'd5, 32'sd7, -32'sd3, 5'd14, -64'sd21, 0};
      tbl[14] = '{3'd6, 32'sd7, -32'sd2, 5'd15, -64'sd3, 33};
      tbl[15] = '{3'd7, 32'sh7fffffff, 32'sh80000000, 5'd16, 64'sh000000007FFFFFFF, 33};

      #1 reset_n = 1'b0;
      #1;
      chk("rst_load_ready", 64'(load_ready), 64'(1));
      chk("rst_wr_done", 64'(wr_done), 64'(0));
      chk("rst_rd_opc", 64'(rd_opc), 64'(0));
      chk("rst_rd_op_a", 64'(rd_op_a), 64'(0));
      chk("rst_rd_op_b", 64'(rd_op_b), 64'(0));
      chk("rst_rd_result", rd_result, 64'(0));
      chk("rst_rd_valid", 64'(rd_valid), 64'(0));
      repeat (2) tick();
      reset_n = 1'b1;
      tick();

      for (int i = 0; i < 16; i++) begin
         do_write(tbl[i].opc, tbl[i].a, tbl[i].b, tbl[i].p, lat, low);
         chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(tbl[i].lat));
         chk($sformatf("vec%0d_ready_low", i), 64'(low), 64'(tbl[i].lat));
         tick();
         chk($sformatf("vec%0d_done_pulse", i), 64'(wr_done), 64'(0));
         read_pointer = tbl[i].p;
         tick();
         chk($sformatf("vec%0d_rd_result", i), rd_result, tbl[i].res);
         chk($sformatf("vec%0d_rd_opc", i), 64'(rd_opc), 64'(tbl[i].opc));
         chk($sformatf("vec%0d_rd_op_a", i), 64'(rd_op_a), 64'(tbl[i].a));
         chk($sformatf("vec%0d_rd_op_b", i), 64'(rd_op_b), 64'(tbl[i].b));
         chk($sformatf("vec%0d_rd_valid", i), 64'(rd_valid), 64'(1));
      end

      // Read-before-write on entry 2 (holds PASSB b=6)
      read_pointer = 5'd2;
      load_en = 1'b1; opcode = 3'd1; operand_a = 32'sd11; operand_b = 32'sd0; write_pointer = 5'd2;
      tick();
      load_en = 1'b0;
      chk("rbw_old_opc", 64'(rd_opc), 64'(2));
      chk("rbw_old_op_b", 64'(rd_op_b), 64'(6));
      chk("rbw_old_result", rd_result, 64'(6));
      chk("rbw_done", 64'(wr_done), 64'(1));
      tick();
      chk("rbw_new_opc", 64'(rd_opc), 64'(1));
      chk("rbw_new_op_a", 64'(rd_op_a), 64'(11));
      chk("rbw_new_result", rd_result, 64'(11));

      pulse_reset();
      read_pointer = 5'd0;
      tick();
      chk("clr_rd_valid0", 64'(rd_valid), 64'(0));
      chk("clr_rd_result0", rd_result, 64'(0));
      read_pointer = 5'd1;
      tick();
      chk("clr_rd_valid1", 64'(rd_valid), 64'(0));
      chk("clr_rd_opc1", 64'(rd_opc), 64'(0));

      model_clear();
      for (int c = 0; c < 1500; c++) rand_cycle(1'b1);
      for (int c = 0; c < 40; c++) rand_cycle(1'b0);

      // Reset while a divide is in flight
      load_en = 1'b1; opcode = 3'd6; operand_a = -32'sd100; operand_b = 32'sd7;
      write_pointer = 5'd5; read_pointer = 5'd0;
      tick();
      load_en = 1'b0;
      chk("abort_busy", 64'(load_ready), 64'(0));
      repeat (10) tick();
      reset_n = 1'b0;
      #1;
      chk("abort_load_ready", 64'(load_ready), 64'(1));
      chk("abort_wr_done", 64'(wr_done), 64'(0));
      chk("abort_rd_valid", 64'(rd_valid), 64'(0));
      tick();
      reset_n = 1'b1;
      n_done = 0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (wr_done) n_done++;
      end
      chk("abort_no_done", 64'(n_done), 64'(0));
      read_pointer = 5'd5;
      tick();
      chk("abort_rd5_valid", 64'(rd_valid), 64'(0));
      chk("abort_rd5_result", rd_result, 64'(0));
      chk("abort_rd5_opc", 64'(rd_opc), 64'(0));

      // DEPTH=24 instance: out-of-range writes and reads
      d2_load_en = 1'b1; d2_opcode = 3'd1; d2_a = 32'sd7; d2_b = 32'sd0; d2_wp = 5'd30;
      tick();
      d2_load_en = 1'b0;
      chk("d24_oob_done", 64'(d2_wr_done), 64'(1));
      d2_rp = 5'd30;
      tick();
      chk("d24_oob_rd_valid", 64'(d2_rd_valid), 64'(0));
      chk("d24_oob_rd_opc", 64'(d2_rd_opc), 64'(0));
      chk("d24_oob_rd_op_a", 64'(d2_rd_op_a), 64'(0));
      chk("d24_oob_rd_op_b", 64'(d2_rd_op_b), 64'(0));
      chk("d24_oob_rd_result", d2_rd_result, 64'(0));
      d2_load_en = 1'b1; d2_opcode = 3'd6; d2_a = 32'sd100; d2_b = 32'sd7; d2_wp = 5'd29;
      tick();
      d2_load_en = 1'b0;
      lat = 0;
      while (!d2_wr_done && lat < 100) begin
         tick();
         lat++;
      end
      chk("d24_oob_div_latency", 64'(lat), 64'(OP_W + 1));
      d2_load_en = 1'b1; d2_opcode = 3'd3; d2_a = 32'sd1; d2_b = 32'sd2; d2_wp = 5'd23;
      tick();
      d2_load_en = 1'b0;
      d2_rp = 5'd23;
      tick();
      chk("d24_top_rd_result", d2_rd_result, 64'(3));
      chk("d24_top_rd_valid", 64'(d2_rd_valid), 64'(1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
